// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the dual-mode systolic processing element.
//   MODE_WS / MODE_OS : encodings of the mode input.
//   pe_widths_legal() : true when the accumulator can hold a full-precision product.
package pe_pkg;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    function automatic bit pe_widths_legal(input int acc_w, input int data_w, input int weight_w);
        return acc_w >= (data_w + weight_w);
    endfunction

endpackage

// File: rtl/sat_add.sv
// sat_add: signed ACC_WIDTH adder with overflow detection.
//   a, b : signed operands
//   sum  : a+b, clamped to the signed range when SATURATE != 0, wrapped otherwise
//   ovf  : high whenever the true sum does not fit in ACC_WIDTH bits
module sat_add #(
    parameter int ACC_WIDTH = 24,
    parameter int SATURATE  = 1
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    localparam logic [ACC_WIDTH-1:0] MAX_VAL = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_VAL = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only possible when both operands share a sign and the result's differs.
        ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
        sum = raw;
        if (ovf && (SATURATE != 0)) begin
            sum = a[ACC_WIDTH-1] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/dual_mode_pe.sv
// dual_mode_pe: systolic processing element with weight-stationary (WS) and
// output-stationary (OS) dataflows, double-buffered weight, saturating
// accumulation, sticky overflow flag and an OS drain chain.
//   clk, reset        : clock, asynchronous active-high reset
//   mode              : 0 = WS, 1 = OS (change only when idle)
//   load, swap        : WS shadow-weight shift / shadow-to-active copy
//   drain             : OS emit accumulator on out_sum
//   in_valid, in_val  : activation from west (in_valid also qualifies in_weight in OS)
//   in_weight         : weight from north
//   in_sum, in_sum_valid : partial sum / drain data from north
//   out_valid, out_val: registered activation to east
//   out_weight        : weight to south
//   out_sum, out_sum_valid : sum to south
//   ovf               : sticky overflow
module dual_mode_pe
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int SATURATE     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    load,
    input  logic                    swap,
    input  logic                    drain,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_val,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    input  logic [ACC_WIDTH-1:0]    in_sum,
    input  logic                    in_sum_valid,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_val,
    output logic [WEIGHT_WIDTH-1:0] out_weight,
    output logic [ACC_WIDTH-1:0]    out_sum,
    output logic                    out_sum_valid,
    output logic                    ovf
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    generate
        if (!pe_widths_legal(ACC_WIDTH, DATA_WIDTH, WEIGHT_WIDTH)) begin : g_bad_widths
            $error("dual_mode_pe: ACC_WIDTH must be >= DATA_WIDTH + WEIGHT_WIDTH");
        end
    endgenerate

    logic                    mode_q_reg;
    logic [WEIGHT_WIDTH-1:0] shadow_reg,        shadow_next;
    logic [WEIGHT_WIDTH-1:0] active_reg,        active_next;
    logic [ACC_WIDTH-1:0]    acc_reg,           acc_next;
    logic                    out_valid_reg,     out_valid_next;
    logic [DATA_WIDTH-1:0]   out_val_reg,       out_val_next;
    logic [WEIGHT_WIDTH-1:0] out_weight_reg,    out_weight_next;
    logic [ACC_WIDTH-1:0]    out_sum_reg,       out_sum_next;
    logic                    out_sum_valid_reg, out_sum_valid_next;
    logic                    ovf_reg,           ovf_next;

    logic                     mode_change;
    logic [WEIGHT_WIDTH-1:0]  multiplicand;
    logic signed [PROD_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]     product_ext;
    logic [ACC_WIDTH-1:0]     addend;
    logic [ACC_WIDTH-1:0]     add_sum;
    logic                     add_ovf;

    assign mode_change  = (mode != mode_q_reg);
    // WS multiplies by the active weight as it was before this edge; OS by the streamed weight.
    assign multiplicand = (mode == MODE_OS) ? in_weight : active_reg;
    assign product      = $signed(in_val) * $signed(multiplicand);
    assign product_ext  = ACC_WIDTH'(product);
    // The single adder is shared: WS adds to the incoming partial sum, OS to the local accumulator.
    assign addend       = (mode == MODE_OS) ? acc_reg : in_sum;

    sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_sat_add (
        .a   (addend),
        .b   (product_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        shadow_next        = shadow_reg;
        active_next        = active_reg;
        acc_next           = acc_reg;
        out_valid_next     = in_valid;
        out_val_next       = in_val;
        out_weight_next    = out_weight_reg;
        out_sum_next       = out_sum_reg;
        out_sum_valid_next = 1'b0;
        ovf_next           = ovf_reg;

        // Weight buffering follows the current mode input, so it is not
        // blocked by the one-cycle mode-change bubble.
        if (mode == MODE_WS) begin
            if (load) begin
                shadow_next     = in_weight;
                out_weight_next = shadow_reg;
            end
            if (swap) begin
                active_next = shadow_reg;
            end
        end

        if (mode_change) begin
            // One idle cycle on a dataflow switch: discard accumulator, emit nothing.
            acc_next = '0;
        end else if (mode == MODE_WS) begin
            out_sum_valid_next = in_valid;
            if (in_valid) begin
                out_sum_next = add_sum;
                if (add_ovf) begin
                    ovf_next = 1'b1;
                end
            end
        end else begin
            if (in_valid) begin
                out_weight_next = in_weight;
            end
            if (drain) begin
                // Emitting the result starts a new accumulation; in_sum is dropped this cycle.
                out_sum_next       = acc_reg;
                out_sum_valid_next = 1'b1;
                ovf_next           = 1'b0;
                acc_next           = in_valid ? product_ext : '0;
            end else begin
                out_sum_next       = in_sum;
                out_sum_valid_next = in_sum_valid;
                if (in_valid) begin
                    acc_next = add_sum;
                    if (add_ovf) begin
                        ovf_next = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q_reg        <= MODE_WS;
            shadow_reg        <= '0;
            active_reg        <= '0;
            acc_reg           <= '0;
            out_valid_reg     <= 1'b0;
            out_val_reg       <= '0;
            out_weight_reg    <= '0;
            out_sum_reg       <= '0;
            out_sum_valid_reg <= 1'b0;
            ovf_reg           <= 1'b0;
        end else begin
            mode_q_reg        <= mode;
            shadow_reg        <= shadow_next;
            active_reg        <= active_next;
            acc_reg           <= acc_next;
            out_valid_reg     <= out_valid_next;
            out_val_reg       <= out_val_next;
            out_weight_reg    <= out_weight_next;
            out_sum_reg       <= out_sum_next;
            out_sum_valid_reg <= out_sum_valid_next;
            ovf_reg           <= ovf_next;
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_val       = out_val_reg;
    assign out_weight    = out_weight_reg;
    assign out_sum       = out_sum_reg;
    assign out_sum_valid = out_sum_valid_reg;
    assign ovf           = ovf_reg;

endmodule

// File: tb/tb_dual_mode_pe.sv
// tb_dual_mode_pe: directed-vector bench for dual_mode_pe. One default PE plus
// two 16-bit-accumulator PEs (saturating and wrapping) sharing the control and
// activation stimulus.
module tb_dual_mode_pe;

    logic               clk = 1'b0;
    logic               reset;
    logic               mode, load, swap, drain, in_valid, in_sum_valid;
    logic signed [7:0]  in_val, in_weight;
    logic signed [23:0] in_sum;
    logic signed [15:0] in_sum16;

    logic               out_valid, out_sum_valid, ovf;
    logic signed [7:0]  out_val, out_weight;
    logic signed [23:0] out_sum;

    logic               s_out_valid, s_out_sum_valid, s_ovf;
    logic signed [7:0]  s_out_val, s_out_weight;
    logic signed [15:0] s_out_sum;

    logic               w_out_valid, w_out_sum_valid, w_ovf;
    logic signed [7:0]  w_out_val, w_out_weight;
    logic signed [15:0] w_out_sum;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dual_mode_pe u_dut (
        .clk(clk), .reset(reset), .mode(mode), .load(load), .swap(swap), .drain(drain),
        .in_valid(in_valid), .in_val(in_val), .in_weight(in_weight), .in_sum(in_sum),
        .in_sum_valid(in_sum_valid), .out_valid(out_valid), .out_val(out_val),
        .out_weight(out_weight), .out_sum(out_sum), .out_sum_valid(out_sum_valid), .ovf(ovf)
    );

    dual_mode_pe #(.ACC_WIDTH(16), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .mode(mode), .load(load), .swap(swap), .drain(drain),
        .in_valid(in_valid), .in_val(in_val), .in_weight(in_weight), .in_sum(in_sum16),
        .in_sum_valid(in_sum_valid), .out_valid(s_out_valid), .out_val(s_out_val),
        .out_weight(s_out_weight), .out_sum(s_out_sum), .out_sum_valid(s_out_sum_valid), .ovf(s_ovf)
    );

    dual_mode_pe #(.ACC_WIDTH(16), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .mode(mode), .load(load), .swap(swap), .drain(drain),
        .in_valid(in_valid), .in_val(in_val), .in_weight(in_weight), .in_sum(in_sum16),
        .in_sum_valid(in_sum_valid), .out_valid(w_out_valid), .out_val(w_out_val),
        .out_weight(w_out_weight), .out_sum(w_out_sum), .out_sum_valid(w_out_sum_valid), .ovf(w_ovf)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; load = 1'b0; swap = 1'b0; drain = 1'b0;
        in_valid = 1'b0; in_sum_valid = 1'b0; in_val = '0; in_weight = '0;
        in_sum = '0; in_sum16 = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_out_sum", out_sum, 0);
        check("rst_out_sum_valid", out_sum_valid, 0);
        check("rst_out_weight", out_weight, 0);
        check("rst_ovf", ovf, 0);

        // WS basic: load 3, swap, compute 100 + (-5)*3
        load = 1'b1; in_weight = 8'sd3; tick();
        check("ws_load_out_weight_old_shadow", out_weight, 0);
        load = 1'b0; swap = 1'b1; tick();
        swap = 1'b0; in_val = -8'sd5; in_sum = 24'sd100; in_valid = 1'b1; tick();
        check("ws_basic_out_sum", out_sum, 85);
        check("ws_basic_out_sum_valid", out_sum_valid, 1);
        check("ws_basic_out_val", out_val, -5);
        check("ws_basic_out_valid", out_valid, 1);
        in_valid = 1'b0; tick();
        check("ws_idle_out_sum_valid", out_sum_valid, 0);
        check("ws_idle_out_sum_hold", out_sum, 85);
        check("ws_idle_out_valid", out_valid, 0);

        // Double buffer: load 7 while computing with active=3
        load = 1'b1; in_weight = 8'sd7; in_val = 8'sd2; in_sum = '0; in_valid = 1'b1; tick();
        check("ws_db_out_sum", out_sum, 6);
        check("ws_db_out_weight", out_weight, 3);
        load = 1'b0; in_valid = 1'b0; swap = 1'b1; tick();
        swap = 1'b0; in_val = 8'sd2; in_valid = 1'b1; tick();
        check("ws_db_after_swap", out_sum, 14);
        // load+swap together: active takes old shadow (7), shadow takes 9
        in_valid = 1'b0; load = 1'b1; swap = 1'b1; in_weight = 8'sd9; tick();
        check("ws_ls_out_weight", out_weight, 7);
        load = 1'b0; swap = 1'b0; in_val = 8'sd1; in_valid = 1'b1; tick();
        check("ws_ls_active_old_shadow", out_sum, 7);

        // Asynchronous reset mid-cycle
        in_valid = 1'b0;
        pulse_reset();
        check("arst_out_sum", out_sum, 0);
        check("arst_out_val", out_val, 0);
        check("arst_out_weight", out_weight, 0);
        check("arst_out_valid", out_valid, 0);

        // OS mode: one clear cycle, then first drain emits 0
        mode = 1'b1; tick();
        check("os_switch_out_sum_valid", out_sum_valid, 0);
        drain = 1'b1; tick();
        check("os_first_drain_sum", out_sum, 0);
        check("os_first_drain_valid", out_sum_valid, 1);
        drain = 1'b0; in_valid = 1'b1;
        in_val = 8'sd2;  in_weight = 8'sd3;  tick();
        in_val = 8'sd4;  in_weight = -8'sd1; tick();
        in_val = -8'sd6; in_weight = 8'sd5;  tick();
        check("os_out_weight_pass", out_weight, 5);
        in_valid = 1'b0; drain = 1'b1; tick();
        check("os_drain_sum", out_sum, -28);
        check("os_drain_valid", out_sum_valid, 1);
        drain = 1'b0; in_sum_valid = 1'b0; tick();
        check("os_drain_one_cycle", out_sum_valid, 0);
        in_sum = 24'sd55; in_sum_valid = 1'b1; tick();
        check("os_pass_sum", out_sum, 55);
        check("os_pass_valid", out_sum_valid, 1);
        in_sum_valid = 1'b0; in_sum = '0; drain = 1'b1; tick();
        check("os_acc_cleared", out_sum, 0);
        // drain with in_valid restarts acc at the product
        in_valid = 1'b1; in_val = 8'sd3; in_weight = 8'sd4; tick();
        in_valid = 1'b0; tick();
        check("os_drain_restart", out_sum, 12);

        // Mode switch 0->1 with in_valid=1: no accumulate in the switch cycle
        drain = 1'b0; mode = 1'b0; tick();
        mode = 1'b1; in_valid = 1'b1; in_val = 8'sd5; in_weight = 8'sd5; tick();
        check("switch_out_sum_valid", out_sum_valid, 0);
        in_val = 8'sd2; in_weight = 8'sd3; tick();
        in_valid = 1'b0; drain = 1'b1; tick();
        check("switch_acc_from_zero", out_sum, 6);
        drain = 1'b0; mode = 1'b0; tick();

        // Saturation with a 16-bit accumulator
        pulse_reset();
        tick();
        load = 1'b1; in_weight = 8'sd1; tick();
        load = 1'b0; swap = 1'b1; tick();
        swap = 1'b0; in_val = 8'sd1; in_sum16 = 16'sd32767; in_sum = '0; in_valid = 1'b1; tick();
        check("sat_out_sum", s_out_sum, 32767);
        check("sat_ovf", s_ovf, 1);
        check("wrap_out_sum", w_out_sum, -32768);
        check("wrap_ovf", w_ovf, 1);
        check("main_no_ovf", ovf, 0);
        in_sum16 = '0; tick();
        check("sat_no_ovf_sum", s_out_sum, 1);
        check("sat_ovf_sticky", s_ovf, 1);
        check("wrap_ovf_sticky", w_ovf, 1);
        in_valid = 1'b0;
        pulse_reset();
        check("sat_ovf_reset", s_ovf, 0);
        check("wrap_ovf_reset", w_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
